// File: rtl/frame_max_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_max_pkg
//  Description : Shared definitions for the frame peak controller: sample
//                width default, FSM state encoding and index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_max_pkg;

    // Width of the shared comparator datapath
    localparam int DW_DEFAULT = 6;

    // Controller state encoding
    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Counter/index width: clog2(frame_len), never narrower than one bit
    function automatic int calc_iw(input int frame_len);
        return (frame_len <= 1) ? 1 : $clog2(frame_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/max6_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : max6_cmp
//  Description : Combinational 6-bit two-input max selector. The newer input
//                wins ties; sel=1 whenever the newer input is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module max6_cmp (
    input  logic [5:0] new_val,
    input  logic [5:0] old_val,
    output logic [5:0] max_val,
    output logic       sel
);

    // new >= old picks the newer sample so the last occurrence is reported
    always_comb begin
        sel     = (new_val >= old_val);
        max_val = sel ? new_val : old_val;
    end

endmodule
`default_nettype wire

// File: rtl/frame_max_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_max_ctrl
//  Description : Time-shares one 6-bit max comparator to find the peak of
//                each FRAME_LEN-sample frame; presents the result on a
//                valid/ready output and stalls input until it is consumed.
//                Optional macro FRAME_MAX_INDEX_EN adds the out_idx port
//                reporting the (last) position of the maximum.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_max_ctrl
    import frame_max_pkg::*;
#(
    parameter  int DW        = DW_DEFAULT,
    parameter  int FRAME_LEN = 16,
    localparam int IW        = calc_iw(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_max,
`ifdef FRAME_MAX_INDEX_EN
    output logic [IW-1:0] out_idx,
`endif
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [IW-1:0] c_last = IW'(FRAME_LEN - 1);

    logic [0:0]    r_state;
    logic [IW-1:0] r_cnt;
    logic [DW-1:0] r_mx;
`ifdef FRAME_MAX_INDEX_EN
    logic [IW-1:0] r_ix;
`endif

    logic [DW-1:0] w_old;
    logic [DW-1:0] w_cmp_max;
    logic          w_sel;

    // First sample of a frame compares against zero, so it is always taken
    assign w_old = (r_cnt == '0) ? '0 : r_mx;

    max6_cmp u_cmp (
        .new_val (in_data),
        .old_val (w_old),
        .max_val (w_cmp_max),
        .sel     (w_sel)
    );

    // Frame sequencing FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ACC;
            r_cnt     <= '0;
            r_mx      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_max   <= '0;
`ifdef FRAME_MAX_INDEX_EN
            r_ix      <= '0;
            out_idx   <= '0;
`endif
        end else if (clr) begin
            // Abort: drop the partial frame and any pending result
            r_state   <= ST_ACC;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (in_valid) begin
                        // mx only moves when the new sample wins
                        if (w_sel) r_mx <= w_cmp_max;
`ifdef FRAME_MAX_INDEX_EN
                        if (w_sel) r_ix <= r_cnt;
`endif
                        if (r_cnt == c_last) begin
                            r_cnt     <= '0;
                            r_state   <= ST_HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_max   <= w_cmp_max;
`ifdef FRAME_MAX_INDEX_EN
                            out_idx   <= w_sel ? r_cnt : r_ix;
`endif
                        end else begin
                            r_cnt <= r_cnt + IW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state   <= ST_ACC;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_ACC;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_max_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_max_ctrl
//  Description : Directed self-checking bench for frame_max_ctrl with
//                FRAME_LEN=4. Index checks compile in only when
//                FRAME_MAX_INDEX_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_max_ctrl;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] out_max;
`ifdef FRAME_MAX_INDEX_EN
    logic [1:0] out_idx;
`endif
    logic       out_valid;
    logic       out_ready;

    int n_cmp = 0;
    int n_err = 0;

    frame_max_ctrl #(
        .FRAME_LEN (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_max   (out_max),
`ifdef FRAME_MAX_INDEX_EN
        .out_idx   (out_idx),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Offer one sample for a single clock edge, then return 1 unit after it
    task automatic push(input logic [5:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idx_chk(input string tag, input logic [31:0] expected);
`ifdef FRAME_MAX_INDEX_EN
        chk(tag, 32'(out_idx), expected);
`else
        if (expected > 32'd3) $display("note: index %0d out of range for %s", expected, tag);
`endif
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_max",   32'(out_max),   32'd0);
        idx_chk("rst_out_idx", 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame 1: 5,17,3,9 -> max 17 at index 1
        push(6'd5); push(6'd17); push(6'd3);
        chk("f1_not_yet_valid", 32'(out_valid), 32'd0);
        push(6'd9);
        chk("f1_valid",    32'(out_valid), 32'd1);
        chk("f1_max",      32'(out_max),   32'd17);
        chk("f1_in_ready", 32'(in_ready),  32'd0);
        idx_chk("f1_idx", 32'd1);
        @(posedge clk); #1;
        chk("f1_drained_valid", 32'(out_valid), 32'd0);
        chk("f1_drained_ready", 32'(in_ready),  32'd1);
        chk("f1_max_held",      32'(out_max),   32'd17);

        // Frame 2: 12,40,40,7 -> max 40, tie resolves to index 2; then backpressure
        out_ready = 1'b0;
        push(6'd12); push(6'd40); push(6'd40); push(6'd7);
        chk("f2_valid", 32'(out_valid), 32'd1);
        chk("f2_max",   32'(out_max),   32'd40);
        idx_chk("f2_idx_tie", 32'd2);
        for (int i = 0; i < 5; i++) begin
            in_data  = 6'd63;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_max",   32'(out_max),   32'd40);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_release_same_cycle_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp_release_in_ready",  32'(in_ready),  32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Frame 3: all zeros; the stalled 63s must not have leaked in
        push(6'd0); push(6'd0); push(6'd0);
        chk("f3_not_yet_valid", 32'(out_valid), 32'd0);
        push(6'd0);
        chk("f3_valid", 32'(out_valid), 32'd1);
        chk("f3_max",   32'(out_max),   32'd0);
        idx_chk("f3_idx_last_tie", 32'd3);
        @(posedge clk); #1;

        // Frame 4: full-scale first sample
        push(6'd63); push(6'd0); push(6'd0); push(6'd0);
        chk("f4_valid", 32'(out_valid), 32'd1);
        chk("f4_max",   32'(out_max),   32'd63);
        idx_chk("f4_idx", 32'd0);
        @(posedge clk); #1;

        // Frame 5: abort after 10,50; sample offered alongside clr is dropped
        out_ready = 1'b0;
        push(6'd10); push(6'd50);
        clr      = 1'b1;
        in_data  = 6'd60;
        in_valid = 1'b1;
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_in_ready",  32'(in_ready),  32'd1);
        chk("clr_max_kept",  32'(out_max),   32'd63);
        push(6'd1); push(6'd2); push(6'd3);
        chk("clr_not_yet_valid", 32'(out_valid), 32'd0);
        push(6'd4);
        chk("clr_valid", 32'(out_valid), 32'd1);
        chk("clr_max",   32'(out_max),   32'd4);
        idx_chk("clr_idx", 32'd3);

        // Asynchronous reset in HOLD, mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_max",   32'(out_max),   32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        idx_chk("arst_out_idx", 32'd0);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        push(6'd20); push(6'd21); push(6'd22);
        chk("post_rst_not_yet_valid", 32'(out_valid), 32'd0);
        push(6'd23);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_max",   32'(out_max),   32'd23);
        idx_chk("post_rst_idx", 32'd3);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
